uart_tx_fifo: RTL and testbench
===============================

Name: uart_tx_fifo

Overview:
Parametrised UART transmitter, successor to the fixed 8N1 transmitter. Adds configurable data width, parity and stop bits, a runtime baud divisor and an input FIFO, so producers can queue bytes without polling busy. Sits between a host/register bus and the serial TX pin. Emits back-to-back frames with no idle gap while the FIFO holds data.

Parameters:
DATA_BITS, 8, data bits per frame; legal range 5..9.
PARITY, 0, parity mode: 0 = none, 1 = odd, 2 = even.
STOP_BITS, 1, stop bits per frame; 1 or 2.
DIV_W, 16, width of the baud divisor input.
FIFO_DEPTH, 4, FIFO entries; power of two, minimum 2.

Ports:
i_clk  in  1  clock.
i_rst  in  1  reset, asynchronous, active-high.
i_div  in  DIV_W  clock cycles per bit; value 234 gives 115200 baud at 27 MHz.
i_data  in  DATA_BITS  word to queue.
i_we  in  1  write strobe; queues i_data when o_full = 0.
o_full  out  1  FIFO full; registered.
o_empty  out  1  FIFO empty; registered.
o_drop  out  1  one-cycle pulse: the write in the previous cycle was discarded because the FIFO was full.
o_busy  out  1  frame in progress (FSM not IDLE).
o_data  out  1  serial line; registered; idles high.

Behaviour:
- Reset (async): FIFO pointers and count cleared, o_empty=1, o_full=0, o_drop=0, o_busy=0, o_data=1, FSM=IDLE, counters 0. Reset mid-frame aborts the frame and returns the line high immediately; queued data is lost.
- FIFO write: i_we=1 and o_full=0 at an edge stores i_data. i_we=1 and o_full=1 drops the word and sets o_drop for the next cycle. This applies even if a pop happens in the same cycle.
- FIFO pop: happens in IDLE when o_empty=0, and at the last cycle of the final stop bit when o_empty=0. A push and pop in the same cycle leave the count unchanged.
- Latency: a word written at edge N is popped at edge N+1 if the FSM is IDLE. The start bit appears on o_data after edge N+1, and o_busy=1 from edge N+1.
- Divisor: i_div is sampled at the pop and held for the whole frame. A sampled value below 2 is treated as 2. Each bit lasts exactly div cycles, using a bit-timer counting 0..div-1.
- FSM: IDLE -> START (o_data=0) -> DATA (DATA_BITS bits, LSB first) -> PARITY (only if PARITY!=0) -> STOP (o_data=1, STOP_BITS bit periods).
  - From STOP: go to START if the FIFO is non-empty (pop, no idle cycle), else go to IDLE.
- Parity bit: even mode = XOR of data bits; odd mode = its inverse. It is computed from the latched word.
- Frame length in cycles = div × (1 + DATA_BITS + (PARITY!=0) + STOP_BITS).
- o_busy falls on the edge after the last stop-bit cycle when no further word is queued. Changes to i_div mid-frame have no effect until the next pop.

Test Plan:
1. DATA_BITS=8, PARITY=0, STOP_BITS=1, i_div=4; write 0x55 -> o_data start 0, then 1,0,1,0,1,0,1,0, stop 1, each held 4 cycles; o_busy high for exactly 40 cycles; o_empty returns to 1 one cycle after the write.
2. PARITY=2, i_div=4; write 0x07 -> parity bit 1. With PARITY=1 and 0x07 -> parity bit 0. Frame is 44 cycles in both cases.
3. STOP_BITS=2, DATA_BITS=7; write 0x41 then 0x42 in consecutive cycles -> two frames back-to-back, stop held 8 cycles, start of the second frame directly follows with no idle cycle, and o_busy stays high throughout.
4. FIFO_DEPTH=4, i_div=4; i_we high for 6 consecutive cycles with data 1..6 -> first word is popped immediately, words 2..5 fill the FIFO (o_full=1), word 6 is dropped with o_drop pulsing for one cycle; exactly 5 frames (1..5) are transmitted.
5. i_div=0 -> each bit lasts 2 cycles. Changing i_div from 4 to 8 mid-frame -> the current frame keeps 4-cycle bits and the next frame uses 8-cycle bits.
6. Assert i_rst in the middle of the data bits of a frame with 2 words queued -> o_data=1, o_busy=0, o_empty=1 immediately; after release the line stays idle with no further frames.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// +--------------------------------------------------------------------------+
// | uart_tx_fifo: FIFO-fed UART transmitter, configurable data/parity/stop.  |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module uart_tx_fifo #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int DIV_W      = 16,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [DIV_W-1:0]     i_div,
  input  logic [DATA_BITS-1:0] i_data,
  input  logic                 i_we,
  output logic                 o_full,
  output logic                 o_empty,
  output logic                 o_drop,
  output logic                 o_busy,
  output logic                 o_data
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = 4;
  localparam logic [DIV_W-1:0] MIN_DIV = DIV_W'(2);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP} state_t;

  logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]       count_q, count_d;
  logic                 full_q, full_d, empty_q, empty_d, drop_q, drop_d;
  state_t               state_q, state_d;
  logic [DATA_BITS-1:0] shreg_q, shreg_d, head;
  logic                 par_q, par_d;
  logic [DIV_W-1:0]     div_q, div_d, tick_q, tick_d;
  logic [CNT_W-1:0]     bitcnt_q, bitcnt_d;
  logic                 busy_q, busy_d, txd_q, txd_d;
  logic                 push, pop, bit_end, last_stop;

  always_comb begin
    push      = i_we & ~full_q;
    bit_end   = (tick_q == div_q - DIV_W'(1));
    last_stop = (state_q == S_STOP) && bit_end && (bitcnt_q == CNT_W'(STOP_BITS - 1));
    pop       = ~empty_q & ((state_q == S_IDLE) | last_stop);
    head      = mem_q[rd_ptr_q];

    // Full is taken from the registered flag, so a same-cycle pop never rescues a write.
    wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    count_d  = count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
    full_d   = (count_d == (PTR_W+1)'(FIFO_DEPTH));
    empty_d  = (count_d == '0);
    drop_d   = i_we & full_q;

    state_d  = state_q;
    shreg_d  = shreg_q;
    par_d    = par_q;
    div_d    = div_q;
    bitcnt_d = bitcnt_q;
    busy_d   = busy_q;
    txd_d    = txd_q;
    tick_d   = (state_q == S_IDLE || bit_end) ? '0 : tick_q + DIV_W'(1);

    if (bit_end) begin
      case (state_q)
        S_START: begin
          state_d  = S_DATA;
          txd_d    = shreg_q[0];
          bitcnt_d = '0;
        end
        S_DATA: begin
          if (bitcnt_q == CNT_W'(DATA_BITS - 1)) begin
            bitcnt_d = '0;
            if (PARITY != 0) begin
              state_d = S_PAR;
              txd_d   = par_q;
            end else begin
              state_d = S_STOP;
              txd_d   = 1'b1;
            end
          end else begin
            bitcnt_d = bitcnt_q + CNT_W'(1);
            shreg_d  = shreg_q >> 1;
            txd_d    = shreg_q[1];
          end
        end
        S_PAR: begin
          state_d = S_STOP;
          txd_d   = 1'b1;
        end
        S_STOP: begin
          if (last_stop) begin
            state_d = S_IDLE;
            txd_d   = 1'b1;
            busy_d  = 1'b0;
          end else begin
            bitcnt_d = bitcnt_q + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end

    // A pop overrides the stop->idle return, giving back-to-back frames.
    if (pop) begin
      state_d  = S_START;
      txd_d    = 1'b0;
      busy_d   = 1'b1;
      shreg_d  = head;
      par_d    = (PARITY == 1) ? ~(^head) : ^head;
      div_d    = (i_div < MIN_DIV) ? MIN_DIV : i_div;
      tick_d   = '0;
      bitcnt_d = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) mem_q[wr_ptr_q] <= i_data;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      drop_q   <= 1'b0;
      state_q  <= S_IDLE;
      shreg_q  <= '0;
      par_q    <= 1'b0;
      div_q    <= '0;
      tick_q   <= '0;
      bitcnt_q <= '0;
      busy_q   <= 1'b0;
      txd_q    <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
      drop_q   <= drop_d;
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      par_q    <= par_d;
      div_q    <= div_d;
      tick_q   <= tick_d;
      bitcnt_q <= bitcnt_d;
      busy_q   <= busy_d;
      txd_q    <= txd_d;
    end
  end

  assign o_full  = full_q;
  assign o_empty = empty_q;
  assign o_drop  = drop_q;
  assign o_busy  = busy_q;
  assign o_data  = txd_q;

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_fifo.sv
// +--------------------------------------------------------------------------+
// | tb_uart_tx_fifo: directed bench over four parameter variants.            |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_uart_tx_fifo;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] div = 16'd4;
  logic [7:0]  dat = 8'h00;
  logic [3:0]  we  = 4'b0000;
  logic [3:0]  od, bz, em, fl, dr;
  int          n_vec = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  // 0: 8N1   1: 8E1   2: 8O1   3: 7N2
  uart_tx_fifo #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .DIV_W(16), .FIFO_DEPTH(4)) u0 (
    .i_clk(clk), .i_rst(rst), .i_div(div), .i_data(dat), .i_we(we[0]),
    .o_full(fl[0]), .o_empty(em[0]), .o_drop(dr[0]), .o_busy(bz[0]), .o_data(od[0]));
  uart_tx_fifo #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .DIV_W(16), .FIFO_DEPTH(4)) u1 (
    .i_clk(clk), .i_rst(rst), .i_div(div), .i_data(dat), .i_we(we[1]),
    .o_full(fl[1]), .o_empty(em[1]), .o_drop(dr[1]), .o_busy(bz[1]), .o_data(od[1]));
  uart_tx_fifo #(.DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .DIV_W(16), .FIFO_DEPTH(4)) u2 (
    .i_clk(clk), .i_rst(rst), .i_div(div), .i_data(dat), .i_we(we[2]),
    .o_full(fl[2]), .o_empty(em[2]), .o_drop(dr[2]), .o_busy(bz[2]), .o_data(od[2]));
  uart_tx_fifo #(.DATA_BITS(7), .PARITY(0), .STOP_BITS(2), .DIV_W(16), .FIFO_DEPTH(4)) u3 (
    .i_clk(clk), .i_rst(rst), .i_div(div), .i_data(dat[6:0]), .i_we(we[3]),
    .o_full(fl[3]), .o_empty(em[3]), .o_drop(dr[3]), .o_busy(bz[3]), .o_data(od[3]));

  task automatic chk_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Frame vector is {stop.., parity, data, start}; index 0 goes out first.
  task automatic check_frame(input int k, input logic [15:0] bits, input int nb, input int dv,
                             input string tag, input bit chk_empty);
    for (int b = 0; b < nb; b++) begin
      for (int c = 0; c < dv; c++) begin
        tick();
        chk_val($sformatf("%s_bit%0d_c%0d", tag, b, c), {31'd0, od[k]}, {31'd0, bits[b]});
        if (c == 0) chk_val($sformatf("%s_busy%0d", tag, b), {31'd0, bz[k]}, 32'd1);
        if (chk_empty && b == 0 && c == 0) chk_val({tag, "_empty"}, {31'd0, em[k]}, 32'd1);
      end
    end
  endtask

  task automatic check_idle(input int k, input string tag);
    tick();
    chk_val({tag, "_busy_end"}, {31'd0, bz[k]}, 32'd0);
    chk_val({tag, "_line_end"}, {31'd0, od[k]}, 32'd1);
  endtask

  task automatic write1(input int k, input logic [7:0] d);
    dat = d;
    we[k] = 1'b1;
    tick();
    we[k] = 1'b0;
  endtask

  initial begin
    #2 rst = 1'b1;
    #1;
    chk_val("rst_empty", {31'd0, em[0]}, 32'd1);
    chk_val("rst_full",  {31'd0, fl[0]}, 32'd0);
    chk_val("rst_drop",  {31'd0, dr[0]}, 32'd0);
    chk_val("rst_busy",  {31'd0, bz[0]}, 32'd0);
    chk_val("rst_line",  {31'd0, od[0]}, 32'd1);
    tick();
    rst = 1'b0;
    tick();

    // 8N1 0x55, 4-cycle bits, 40-cycle busy window
    write1(0, 8'h55);
    chk_val("t1_empty_after_wr", {31'd0, em[0]}, 32'd0);
    chk_val("t1_busy_before",    {31'd0, bz[0]}, 32'd0);
    check_frame(0, {6'd0, 1'b1, 8'h55, 1'b0}, 10, 4, "t1", 1'b1);
    check_idle(0, "t1");

    // even parity of 0x07 is 1, odd parity is 0
    write1(1, 8'h07);
    check_frame(1, {5'd0, 1'b1, 1'b1, 8'h07, 1'b0}, 11, 4, "t2e", 1'b1);
    check_idle(1, "t2e");
    write1(2, 8'h07);
    check_frame(2, {5'd0, 1'b1, 1'b0, 8'h07, 1'b0}, 11, 4, "t2o", 1'b1);
    check_idle(2, "t2o");

    // 7N2 back-to-back 0x41, 0x42
    dat = 8'h41;
    we[3] = 1'b1;
    tick();
    dat = 8'h42;
    fork
      begin
        tick();
        we[3] = 1'b0;
      end
      begin
        check_frame(3, {6'd0, 2'b11, 7'h41, 1'b0}, 10, 4, "t3a", 1'b0);
        check_frame(3, {6'd0, 2'b11, 7'h42, 1'b0}, 10, 4, "t3b", 1'b0);
      end
    join
    check_idle(3, "t3");

    // six writes into a 4-deep FIFO: word 6 dropped
    dat = 8'd1;
    we[0] = 1'b1;
    tick();
    fork
      begin
        for (int i = 2; i <= 6; i++) begin
          dat = 8'(i);
          tick();
          if (i == 4) chk_val("t4_full_3q", {31'd0, fl[0]}, 32'd0);
          if (i == 5) begin
            chk_val("t4_full_4q", {31'd0, fl[0]}, 32'd1);
            chk_val("t4_drop_pre", {31'd0, dr[0]}, 32'd0);
          end
          if (i == 6) chk_val("t4_drop", {31'd0, dr[0]}, 32'd1);
        end
        we[0] = 1'b0;
        tick();
        chk_val("t4_drop_clr", {31'd0, dr[0]}, 32'd0);
        chk_val("t4_full_hold", {31'd0, fl[0]}, 32'd1);
      end
      begin
        for (int f = 1; f <= 5; f++)
          check_frame(0, {6'd0, 1'b1, 8'(f), 1'b0}, 10, 4, $sformatf("t4f%0d", f), 1'b0);
      end
    join
    check_idle(0, "t4");
    for (int i = 0; i < 12; i++) begin
      tick();
      chk_val("t4_no_sixth", {31'd0, bz[0]}, 32'd0);
    end
    chk_val("t4_empty_end", {31'd0, em[0]}, 32'd1);

    // divisor 0 clamps to 2
    div = 16'd0;
    write1(0, 8'hA3);
    check_frame(0, {6'd0, 1'b1, 8'hA3, 1'b0}, 10, 2, "t5a", 1'b1);
    check_idle(0, "t5a");

    // divisor change mid-frame takes effect on the next pop
    div = 16'd4;
    dat = 8'h5A;
    we[0] = 1'b1;
    tick();
    dat = 8'h3C;
    fork
      begin
        tick();
        we[0] = 1'b0;
        repeat (10) tick();
        div = 16'd8;
      end
      begin
        check_frame(0, {6'd0, 1'b1, 8'h5A, 1'b0}, 10, 4, "t5b", 1'b0);
        check_frame(0, {6'd0, 1'b1, 8'h3C, 1'b0}, 10, 8, "t5c", 1'b0);
      end
    join
    check_idle(0, "t5c");

    // async reset mid-frame with two words queued
    div = 16'd4;
    dat = 8'd1;
    we[0] = 1'b1;
    tick();
    dat = 8'd2;
    tick();
    dat = 8'd3;
    tick();
    we[0] = 1'b0;
    repeat (6) tick();
    chk_val("t6_busy_pre", {31'd0, bz[0]}, 32'd1);
    chk_val("t6_empty_pre", {31'd0, em[0]}, 32'd0);
    #2 rst = 1'b1;
    #1;
    chk_val("t6_line_rst",  {31'd0, od[0]}, 32'd1);
    chk_val("t6_busy_rst",  {31'd0, bz[0]}, 32'd0);
    chk_val("t6_empty_rst", {31'd0, em[0]}, 32'd1);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick();
      chk_val("t6_idle_line", {31'd0, od[0]}, 32'd1);
      chk_val("t6_idle_busy", {31'd0, bz[0]}, 32'd0);
    end
    chk_val("t6_empty_end", {31'd0, em[0]}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
